// File: rtl/pc_seq_pkg.sv
// pc_pkg: default sizes and the priority-decoded operation type for pc_seq.
package pc_pkg;
    localparam int PSIZE  = 5;
    localparam int OSIZE  = 4;
    localparam int SDEPTH = 4;
    typedef enum logic [2:0] {OP_HOLD, OP_INCR, OP_REL, OP_ABS, OP_CALL, OP_RET} pc_op_e;
endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: decoder-to-sequencer strobes and sequencer status outputs.
interface pc_seq_if #(
    parameter int Psize  = pc_pkg::PSIZE,
    parameter int Osize  = pc_pkg::OSIZE,
    parameter int Sdepth = pc_pkg::SDEPTH
);
    localparam int SPW = $clog2(Sdepth + 1);
    logic stall, PCincr, PCabsbranch, PCrelbranch, PCcall, PCret, clr_err;
    logic [Psize-1:0] Branchaddr;
    logic [Osize-1:0] Reloffset;
    logic [Psize-1:0] PCout;
    logic [SPW-1:0] sp;
    logic ras_full, ras_empty, ras_ovf, ras_unf;
    modport master (
        output stall, PCincr, PCabsbranch, PCrelbranch, PCcall, PCret, clr_err, Branchaddr, Reloffset,
        input  PCout, sp, ras_full, ras_empty, ras_ovf, ras_unf
    );
    modport slave (
        input  stall, PCincr, PCabsbranch, PCrelbranch, PCcall, PCret, clr_err, Branchaddr, Reloffset,
        output PCout, sp, ras_full, ras_empty, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_seq_ras.sv
// pc_ras: return-address LIFO; push ignored when full, pop ignored when empty.
module pc_ras #(
    parameter int Psize  = 5,
    parameter int Sdepth = 4,
    localparam int SPW   = $clog2(Sdepth + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic             pop,
    input  logic [Psize-1:0] din,
    output logic [Psize-1:0] dout,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty
);
    logic [Psize-1:0] mem_q [Sdepth];
    logic [Psize-1:0] mem_d [Sdepth];
    logic [SPW-1:0] sp_q, sp_d;

    assign full  = sp_q == SPW'(Sdepth);
    assign empty = sp_q == '0;
    assign sp    = sp_q;
    assign dout  = empty ? '0 : mem_q[sp_q - 1'b1];

    always_comb begin
        mem_d = mem_q;
        if (push && !full) mem_d[sp_q] = din;
        sp_d = (push && !full) ? sp_q + 1'b1 : (pop && !empty) ? sp_q - 1'b1 : sp_q;
    end

    // Storage is deliberately not reset; only the pointer is.
    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) sp_q <= '0;
        else sp_q <= sp_d;
endmodule

// File: rtl/pc_seq.sv
// pc_seq: picoMIPS program sequencer with return-address stack and sticky error flags.
// Relative branch is built only when PC_RELBRANCH_EN is defined.
module pc_seq import pc_pkg::*; #(
    parameter int Psize  = PSIZE,
    parameter int Osize  = OSIZE,
    parameter int Sdepth = SDEPTH
) (
    input logic    clk,
    input logic    nreset,
    pc_seq_if.slave bus
);
    localparam int SPW = $clog2(Sdepth + 1);
    pc_op_e op;
    logic [Psize-1:0] pc_q, pc_d, pc_inc, rel_pc, ras_top;
    logic ovf_q, ovf_d, unf_q, unf_d, rel_req, ras_full, ras_empty;
    logic [SPW-1:0] ras_sp;

`ifdef PC_RELBRANCH_EN
    logic signed [Osize-1:0] rel_off;
    assign rel_off = bus.Reloffset;
    assign rel_req = bus.PCrelbranch;
    assign rel_pc  = pc_q + Psize'(rel_off);
`else
    logic [Osize-1:0] unused_off;
    logic unused_rel;
    assign unused_off = bus.Reloffset;
    assign unused_rel = bus.PCrelbranch;
    assign rel_req    = 1'b0;
    assign rel_pc     = pc_q;
`endif

    always_comb begin
        op = bus.stall       ? OP_HOLD :
             bus.PCret       ? OP_RET  :
             bus.PCcall      ? OP_CALL :
             bus.PCabsbranch ? OP_ABS  :
             rel_req         ? OP_REL  :
             bus.PCincr      ? OP_INCR : OP_HOLD;
    end

    pc_ras #(.Psize(Psize), .Sdepth(Sdepth)) u_ras (
        .clk(clk), .nreset(nreset),
        .push(op == OP_CALL), .pop(op == OP_RET),
        .din(pc_inc), .dout(ras_top),
        .sp(ras_sp), .full(ras_full), .empty(ras_empty)
    );

    always_comb begin
        pc_inc = pc_q + 1'b1;
        pc_d = op == OP_RET                     ? (ras_empty ? pc_inc : ras_top) :
               (op == OP_CALL || op == OP_ABS)  ? bus.Branchaddr :
               op == OP_REL                     ? rel_pc :
               op == OP_INCR                    ? pc_inc : pc_q;
        // An error event in the same cycle beats clr_err.
        ovf_d = (op == OP_CALL && ras_full)  ? 1'b1 : bus.clr_err ? 1'b0 : ovf_q;
        unf_d = (op == OP_RET  && ras_empty) ? 1'b1 : bus.clr_err ? 1'b0 : unf_q;
    end

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end

    assign bus.PCout     = pc_q;
    assign bus.sp        = ras_sp;
    assign bus.ras_full  = ras_full;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: scoreboard bench for pc_seq against a stack-based reference model.
module tb_pc_seq;
    import pc_pkg::*;
    localparam int N = 1 << PSIZE;
`ifdef PC_RELBRANCH_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    typedef struct {int pc; int sp; bit ovf; bit unf;} exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    pc_seq_if bus();
    pc_seq dut (.clk(clk), .nreset(nreset), .bus(bus));

    exp_t q[$];
    int m_pc;
    int stk[$];
    bit m_ovf, m_unf;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0;
        stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic void model_step(input bit st, r, c, a, rl, i, input int ba, input logic [OSIZE-1:0] ro, input bit cl);
        bit eo = 0, eu = 0;
        int off = int'($signed(ro));
        if (!st) begin
            if (r) begin
                if (stk.size() > 0) m_pc = stk.pop_back();
                else begin m_pc = (m_pc + 1) % N; eu = 1; end
            end else if (c) begin
                if (stk.size() < SDEPTH) stk.push_back((m_pc + 1) % N);
                else eo = 1;
                m_pc = ba;
            end else if (a) m_pc = ba;
            else if (rl && REL) m_pc = (m_pc + off + N) % N;
            else if (i) m_pc = (m_pc + 1) % N;
        end
        m_ovf = eo ? 1'b1 : cl ? 1'b0 : m_ovf;
        m_unf = eu ? 1'b1 : cl ? 1'b0 : m_unf;
    endfunction

    task automatic cyc(input bit st, r, c, a, rl, i, input int ba, input logic [OSIZE-1:0] ro, input bit cl);
        exp_t e;
        bus.stall = st; bus.PCret = r; bus.PCcall = c; bus.PCabsbranch = a;
        bus.PCrelbranch = rl; bus.PCincr = i; bus.Branchaddr = PSIZE'(ba);
        bus.Reloffset = ro; bus.clr_err = cl;
        model_step(st, r, c, a, rl, i, ba, ro, cl);
        e.pc = m_pc; e.sp = stk.size(); e.ovf = m_ovf; e.unf = m_unf;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        chk("rst_pc", bus.PCout, 0);
        chk("rst_sp", bus.sp, 0);
        chk("rst_empty", bus.ras_empty, 1);
        chk("rst_full", bus.ras_full, 0);
        chk("rst_ovf", bus.ras_ovf, 0);
        chk("rst_unf", bus.ras_unf, 0);
    endtask

    // Monitor: every clocked cycle with a pending expectation is compared.
    initial forever begin
        @(posedge clk);
        #1;
        if (nreset && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", bus.PCout, e.pc);
            chk("sp", bus.sp, e.sp);
            chk("full", bus.ras_full, e.sp == SDEPTH);
            chk("empty", bus.ras_empty, e.sp == 0);
            chk("ovf", bus.ras_ovf, e.ovf);
            chk("unf", bus.ras_unf, e.unf);
        end
    end

    initial begin
        cyc_idle_init();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state();
        nreset = 1'b1;
        repeat (33) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 10, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 4'b1101, 0);
        cyc(0, 0, 0, 1, 0, 0, 30, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 4'b0111, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 4'b0010, 0);
        cyc(0, 0, 0, 1, 0, 0, 3, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 20, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 0, 0, 6 + 5 * k, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 17, 0, 0);
        cyc(1, 1, 1, 1, 1, 1, 9, 4'b0001, 0);
        cyc(0, 1, 1, 1, 1, 1, 9, 4'b0001, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 12, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 25, 0, 0);
        #2;
        nreset = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        q.delete();
        @(negedge clk);
        nreset = 1'b1;
        for (int k = 0; k < 600; k++) begin
            int sel = $urandom_range(0, 15);
            cyc($urandom_range(0, 9) == 0, sel < 3, sel >= 3 && sel < 6, sel == 6 || $urandom_range(0, 7) == 0,
                sel == 7 || sel == 8, sel >= 9 || $urandom_range(0, 1) == 1,
                $urandom_range(0, N - 1), OSIZE'($urandom), $urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #2;
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic cyc_idle_init();
        bus.stall = 0; bus.PCret = 0; bus.PCcall = 0; bus.PCabsbranch = 0;
        bus.PCrelbranch = 0; bus.PCincr = 0; bus.Branchaddr = '0;
        bus.Reloffset = '0; bus.clr_err = 0;
    endtask
endmodule
